// File: rtl/game_pkg.sv
// Shared definitions for the game round controller: FSM state encoding,
// default timing/round constants and the pattern clean-up helper.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SHOW = 3'd1,
        CHK0 = 3'd2,
        CHK1 = 3'd3,
        CHK2 = 3'd4,
        NEXT = 3'd5,
        GAP  = 3'd6,
        DONE = 3'd7
    } state_t;

    localparam int         DEF_WINDOW_CYCLES = 25_000_000;
    localparam int         DEF_GAP_CYCLES    = 12_500_000;
    localparam int         DEF_NUM_ROUNDS    = 10;
    localparam logic [7:0] DEF_LFSR_SEED     = 8'hA5;

    // Width of the shared SHOW/GAP down-counter; comfortably covers the
    // default one-second window at 25 MHz.
    localparam int         CNT_W             = 32;

    // Turns an LFSR value into a displayable pattern: the three LSBs, with
    // an all-dark pattern (or a corrupted all-zero LFSR) replaced by 3'b001.
    function automatic logic [2:0] fix_pattern(input logic [7:0] lfsr_val);
        logic [2:0] result;
        result = lfsr_val[2:0];
        if (lfsr_val == 8'h00 || lfsr_val[2:0] == 3'b000) begin
            result = 3'b001;
        end
        return result;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit maximal-length Fibonacci LFSR (x^8 + x^6 + x^5 + x^4 + 1).
// Advances one step per 'step' pulse; reset loads the seed.
module lfsr8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic fb;

    assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

    // Shift register update; an all-zero seed or state is forced to 1 so the
    // sequence can never lock up.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= (seed == 8'h00) ? 8'h01 : seed;
        end else if (q == 8'h00) begin
            q <= 8'h01;
        end else if (step) begin
            q <= {q[6:0], fb};
        end
    end

endmodule

// File: rtl/game_round_ctrl.sv
// Reaction-game round controller: shows a pseudo-random 3-LED pattern for a
// fixed window, latches button presses, scores each position, and sequences
// a fixed number of rounds separated by blank gaps.
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int         WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int         GAP_CYCLES    = DEF_GAP_CYCLES,
    parameter int         NUM_ROUNDS    = DEF_NUM_ROUNDS,
    parameter logic [7:0] LFSR_SEED     = DEF_LFSR_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       b1,
    input  logic       b2,
    input  logic       b3,
    output logic [2:0] LED,
    output logic       Point,
    output logic       valid,
    output logic [7:0] score,
    output logic [3:0] round_num,
    output logic       busy,
    output logic       game_over
);

    localparam logic [CNT_W-1:0] WIN_LOAD   = WINDOW_CYCLES - 1;
    localparam logic [CNT_W-1:0] GAP_LOAD   = GAP_CYCLES - 1;
    localparam logic [CNT_W-1:0] CNT_ONE    = 1;
    localparam logic [3:0]       LAST_ROUND = 4'(NUM_ROUNDS - 1);

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       pattern;
    logic [2:0]       btn;
    logic [7:0]       lfsr_q;

    logic             load_round;
    logic             new_game;
    logic             enter_gap;
    logic             chk_en;
    logic             chk_hit;

    lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .step (load_round),
        .seed (LFSR_SEED),
        .q    (lfsr_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic and per-state control strobes for the datapath.
    always_comb begin
        state_d    = state;
        load_round = 1'b0;
        new_game   = 1'b0;
        enter_gap  = 1'b0;
        chk_en     = 1'b0;
        chk_hit    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    new_game   = 1'b1;
                    load_round = 1'b1;
                    state_d    = SHOW;
                end
            end
            SHOW: begin
                if (cnt == '0) begin
                    state_d = CHK0;
                end
            end
            CHK0: begin
                chk_en  = 1'b1;
                chk_hit = (pattern[0] == btn[0]);
                state_d = CHK1;
            end
            CHK1: begin
                chk_en  = 1'b1;
                chk_hit = (pattern[1] == btn[1]);
                state_d = CHK2;
            end
            CHK2: begin
                chk_en  = 1'b1;
                chk_hit = (pattern[2] == btn[2]);
                state_d = NEXT;
            end
            NEXT: begin
                if (round_num == LAST_ROUND) begin
                    state_d = DONE;
                end else begin
                    enter_gap = 1'b1;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    load_round = 1'b1;
                    state_d    = SHOW;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shared SHOW/GAP timer: reloads on entry, counts down, parks at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load_round) begin
            cnt <= WIN_LOAD;
        end else if (enter_gap) begin
            cnt <= GAP_LOAD;
        end else if ((state == SHOW || state == GAP) && cnt != '0) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    // Pattern for the round, taken from the LFSR as it steps.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern <= 3'b000;
        end else if (load_round) begin
            pattern <= fix_pattern(lfsr_q);
        end
    end

    // Sticky button capture, only open while the pattern is shown.
    always_ff @(posedge clk) begin
        if (rst || load_round) begin
            btn <= 3'b000;
        end else if (state == SHOW) begin
            btn <= btn | {b3, b2, b1};
        end
    end

    // One-cycle result pulse following each check state.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            Point <= 1'b0;
        end else begin
            valid <= chk_en;
            Point <= chk_en & chk_hit;
        end
    end

    // Saturating score, cleared when a new game starts.
    always_ff @(posedge clk) begin
        if (rst || new_game) begin
            score <= 8'd0;
        end else if (chk_en && chk_hit && score != 8'hFF) begin
            score <= score + 8'd1;
        end
    end

    // Round index, advanced only when another round follows.
    always_ff @(posedge clk) begin
        if (rst || new_game) begin
            round_num <= 4'd0;
        end else if (enter_gap) begin
            round_num <= round_num + 4'd1;
        end
    end

    assign LED       = (state == SHOW) ? pattern : 3'b000;
    assign busy      = (state != IDLE) && (state != DONE);
    assign game_over = (state == DONE);

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl with an 8-cycle window, 4-cycle gap and
// two rounds per game. Expected LFSR patterns from seed 8'hA5:
// 101, 010, 101, 010, 100, 001, 011, 111, 110, 101, ...
module tb_game_round_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       b1;
    logic       b2;
    logic       b3;
    logic [2:0] LED;
    logic       Point;
    logic       valid;
    logic [7:0] score;
    logic [3:0] round_num;
    logic       busy;
    logic       game_over;

    int         total;
    int         bad;
    int         pulses;
    logic [7:0] exp_score;
    logic [3:0] exp_round;

    typedef struct {
        logic       rst;
        logic       start;
        logic [2:0] btns;
        logic [2:0] led;
        logic       pt;
        logic       vld;
        logic [7:0] score;
        logic [3:0] rnd;
        logic       busy;
        logic       over;
    } vec_t;

    vec_t vecs[$];

    game_round_ctrl #(
        .WINDOW_CYCLES (8),
        .GAP_CYCLES    (4),
        .NUM_ROUNDS    (2),
        .LFSR_SEED     (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .b1        (b1),
        .b2        (b2),
        .b3        (b3),
        .LED       (LED),
        .Point     (Point),
        .valid     (valid),
        .score     (score),
        .round_num (round_num),
        .busy      (busy),
        .game_over (game_over)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
    end
    always #5 clk = ~clk;

    // Counts valid pulses on the falling edge.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            pulses <= pulses + 1;
        end
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic r, input logic s, input logic [2:0] b);
        rst   = r;
        start = s;
        {b3, b2, b1} = b;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic addV(input logic r, input logic s, input logic [2:0] b,
                        input logic [2:0] led, input logic pt, input logic vld,
                        input logic [7:0] sc, input logic [3:0] rn,
                        input logic bz, input logic ov);
        vec_t v;
        v.rst   = r;
        v.start = s;
        v.btns  = b;
        v.led   = led;
        v.pt    = pt;
        v.vld   = vld;
        v.score = sc;
        v.rnd   = rn;
        v.busy  = bz;
        v.over  = ov;
        vecs.push_back(v);
    endtask

    task automatic startGame();
        applyStimulus(1'b0, 1'b1, 3'b000);
        exp_score = 8'd0;
        exp_round = 4'd0;
        checkOutput("start score", score, exp_score);
        checkOutput("start round", round_num, exp_round);
        checkOutput("start busy", busy, 1);
        checkOutput("start over", game_over, 0);
    endtask

    // Plays one round from the first observed SHOW cycle, holding 'press'
    // through the whole window, and ends in the next SHOW or in DONE.
    task automatic playRound(input logic [2:0] pat, input logic [2:0] press, input bit last);
        logic pt;
        checkOutput("show led", LED, pat);
        checkOutput("show busy", busy, 1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, press);
        end
        checkOutput("chk0 led", LED, 0);
        checkOutput("chk0 valid", valid, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 3'b000);
            pt = (pat[k] == press[k]);
            if (pt) begin
                exp_score = exp_score + 8'd1;
            end
            checkOutput($sformatf("pos%0d valid", k), valid, 1);
            checkOutput($sformatf("pos%0d point", k), Point, pt);
            checkOutput($sformatf("pos%0d score", k), score, exp_score);
        end
        applyStimulus(1'b0, 1'b0, 3'b000);
        checkOutput("post valid", valid, 0);
        checkOutput("post point", Point, 0);
        if (last) begin
            checkOutput("done over", game_over, 1);
            checkOutput("done busy", busy, 0);
            checkOutput("done round", round_num, exp_round);
            checkOutput("done score", score, exp_score);
        end else begin
            exp_round = exp_round + 4'd1;
            checkOutput("gap round", round_num, exp_round);
            checkOutput("gap over", game_over, 0);
            for (int i = 0; i < 3; i++) begin
                applyStimulus(1'b0, 1'b0, 3'b000);
            end
            checkOutput("gap end led", LED, 0);
            applyStimulus(1'b0, 1'b0, 3'b000);
        end
    endtask

    // Main sequence: table-driven first game, then hand-written games,
    // mid-round reset and replay.
    initial begin
        total  = 0;
        bad    = 0;
        pulses = 0;
        exp_score = 8'd0;
        exp_round = 4'd0;
        rst   = 1'b1;
        start = 1'b0;
        {b3, b2, b1} = 3'b000;

        addV(1, 0, 3'b000, 3'b000, 0, 0, 8'd0, 4'd0, 0, 0);
        addV(0, 1, 3'b000, 3'b101, 0, 0, 8'd0, 4'd0, 1, 0);
        for (int e = 2; e <= 8; e++) begin
            addV(0, 0, (e == 3) ? 3'b001 : ((e == 5) ? 3'b100 : 3'b000),
                 3'b101, 0, 0, 8'd0, 4'd0, 1, 0);
        end
        addV(0, 0, 3'b000, 3'b000, 0, 0, 8'd0, 4'd0, 1, 0);
        addV(0, 0, 3'b000, 3'b000, 1, 1, 8'd1, 4'd0, 1, 0);
        addV(0, 0, 3'b000, 3'b000, 1, 1, 8'd2, 4'd0, 1, 0);
        addV(0, 0, 3'b000, 3'b000, 1, 1, 8'd3, 4'd0, 1, 0);
        addV(0, 0, 3'b010, 3'b000, 0, 0, 8'd3, 4'd1, 1, 0);
        addV(0, 1, 3'b010, 3'b000, 0, 0, 8'd3, 4'd1, 1, 0);
        addV(0, 0, 3'b010, 3'b000, 0, 0, 8'd3, 4'd1, 1, 0);
        addV(0, 0, 3'b010, 3'b000, 0, 0, 8'd3, 4'd1, 1, 0);
        addV(0, 0, 3'b010, 3'b010, 0, 0, 8'd3, 4'd1, 1, 0);
        for (int e = 18; e <= 24; e++) begin
            addV(0, 0, 3'b000, 3'b010, 0, 0, 8'd3, 4'd1, 1, 0);
        end
        addV(0, 0, 3'b000, 3'b000, 0, 0, 8'd3, 4'd1, 1, 0);
        addV(0, 0, 3'b000, 3'b000, 1, 1, 8'd4, 4'd1, 1, 0);
        addV(0, 0, 3'b000, 3'b000, 0, 1, 8'd4, 4'd1, 1, 0);
        addV(0, 0, 3'b000, 3'b000, 1, 1, 8'd5, 4'd1, 1, 0);
        addV(0, 0, 3'b000, 3'b000, 0, 0, 8'd5, 4'd1, 0, 1);
        addV(0, 0, 3'b111, 3'b000, 0, 0, 8'd5, 4'd1, 0, 1);
        addV(0, 0, 3'b000, 3'b000, 0, 0, 8'd5, 4'd1, 0, 1);
        addV(0, 1, 3'b000, 3'b101, 0, 0, 8'd0, 4'd0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].btns);
            checkOutput($sformatf("v%0d led", i), LED, vecs[i].led);
            checkOutput($sformatf("v%0d point", i), Point, vecs[i].pt);
            checkOutput($sformatf("v%0d valid", i), valid, vecs[i].vld);
            checkOutput($sformatf("v%0d score", i), score, vecs[i].score);
            checkOutput($sformatf("v%0d round", i), round_num, vecs[i].rnd);
            checkOutput($sformatf("v%0d busy", i), busy, vecs[i].busy);
            checkOutput($sformatf("v%0d over", i), game_over, vecs[i].over);
        end
        checkOutput("game1 valid pulses", pulses, 6);

        exp_score = 8'd0;
        exp_round = 4'd0;
        playRound(3'b101, 3'b000, 0);
        playRound(3'b010, 3'b000, 1);
        startGame();
        playRound(3'b100, 3'b000, 0);
        playRound(3'b001, 3'b000, 1);
        startGame();
        playRound(3'b011, 3'b000, 0);
        playRound(3'b111, 3'b000, 1);
        startGame();
        playRound(3'b110, 3'b000, 0);

        applyStimulus(1'b0, 1'b0, 3'b000);
        applyStimulus(1'b0, 1'b0, 3'b000);
        applyStimulus(1'b1, 1'b1, 3'b111);
        checkOutput("rst led", LED, 0);
        checkOutput("rst point", Point, 0);
        checkOutput("rst valid", valid, 0);
        checkOutput("rst score", score, 0);
        checkOutput("rst round", round_num, 0);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst over", game_over, 0);
        applyStimulus(1'b1, 1'b1, 3'b000);
        checkOutput("rst prio busy", busy, 0);
        checkOutput("rst prio led", LED, 0);

        startGame();
        playRound(3'b101, 3'b101, 0);
        playRound(3'b010, 3'b000, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
